// File: rtl/xbar_cfg.sv
// Scan-configured crossbar: each of N_OUT outputs picks one of N_IN inputs via a SEL_W-bit field.
// Latency: data path 0 cycles (1 cycle when XBAR_OUT_REG_EN is defined); config visible 1 cycle after commit edge (2 if registered).
// Backpressure: none; a commit without a full frame is dropped and flagged on io_cfg_err for one cycle.
module xbar_cfg #(
    parameter int N_IN  = 27,
    parameter int N_OUT = 35,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  io_xbar_in,
    output logic [N_OUT-1:0] io_xbar_out,
    input  logic             io_cfg_shift,
    input  logic             io_cfg_bit,
    input  logic             io_cfg_commit,
    output logic             io_cfg_ready,
    output logic             io_cfg_err,
    output logic             io_cfg_scan_out
);

    localparam int CFG_BITS = N_OUT * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam int PAD_W    = 1 << SEL_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                commit_ok;

    logic [PAD_W-1:0]    in_pad;
    logic [N_OUT-1:0]    route;

    // Next-state for the scan chain, frame counter, active config and error pulse.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        commit_ok = io_cfg_commit && (cnt_q == CNT_FULL);

        // New bits enter at the top; the oldest bit sits at [0] and leaves next.
        if (io_cfg_shift) begin
            shadow_d = {io_cfg_bit, shadow_q[CFG_BITS-1:1]};
        end

        if (commit_ok) begin
            // Active takes the pre-shift shadow so a same-cycle shift starts the next frame.
            active_d = shadow_q;
            cnt_d    = io_cfg_shift ? CNT_ONE : '0;
        end else begin
            err_d = io_cfg_commit;
            if (io_cfg_shift && (cnt_q != CNT_FULL)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Config state registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Output mux: inputs zero-padded to 2^SEL_W so out-of-range selects read 0.
    always_comb begin
        in_pad             = '0;
        in_pad[N_IN-1:0]   = io_xbar_in;
        route              = '0;
        for (int k = 0; k < N_OUT; k++) begin
            route[k] = in_pad[active_q[k*SEL_W +: SEL_W]];
        end
    end

`ifdef XBAR_OUT_REG_EN
    logic [N_OUT-1:0] out_q, out_d;

    // Registered output stage input.
    always_comb begin
        out_d = route;
    end

    // Registered output stage, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign io_xbar_out = out_q;
`else
    assign io_xbar_out = route;
`endif

    assign io_cfg_ready    = (cnt_q == CNT_FULL);
    assign io_cfg_err      = err_q;
    assign io_cfg_scan_out = shadow_q[0];

endmodule
